// File: rtl/apb_pkg.sv
// Shared types for the APB requester: FSM state encoding, response payload and
// the wait-counter sizing helper.
package apb_pkg;

    localparam int unsigned APB_ADDR_W = 32;
    localparam int unsigned APB_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  err;
        logic                  timeout;
    } apb_rsp_t;

    // A disabled timeout still needs a one-bit counter to keep the ports legal.
    function automatic int unsigned wait_cnt_w(input int unsigned timeout);
        if (timeout == 0) begin
            return 1;
        end
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Clearable, saturating count of PREADY=0 cycles spent in ACCESS; flags when the
// programmed limit is reached.
module apb_wait_timer
    import apb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic inc_i,
    output logic expired_c
);

    localparam int unsigned      CNT_W   = wait_cnt_w(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = (TIMEOUT == 0) ? {CNT_W{1'b1}} : CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Saturate at the limit so a long stall can never wrap back below it.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_c = (TIMEOUT != 0) && (cnt_q == CNT_MAX);

endmodule

// File: rtl/apb_master.sv
// APB requester: turns single-beat valid/ready commands into SETUP/ACCESS
// transfers and returns one registered response per command.
module apb_master
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = APB_ADDR_W,
    parameter int unsigned DATA_WIDTH = APB_DATA_W,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,

    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,

    output logic                  PSELx,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    apb_state_e            state_q;
    logic                  psel_q;
    logic                  penable_q;
    logic                  pwrite_q;
    logic [ADDR_WIDTH-1:0] paddr_q;
    logic [DATA_WIDTH-1:0] pwdata_q;
    logic                  rsp_valid_q;
    apb_rsp_t              rsp_q;

    logic                  timer_clr;
    logic                  timer_inc;
    logic                  timer_expired;

    // Counter clears on the edge that enters SETUP and counts stalled ACCESS edges.
    assign timer_clr = (state_q == ST_IDLE) && cmd_valid;
    assign timer_inc = (state_q == ST_ACCESS) && !PREADY;

    apb_wait_timer #(
        .TIMEOUT   (TIMEOUT)
    ) u_wait_timer (
        .clk       (PCLK),
        .rst_n     (PRESETn),
        .clr_i     (timer_clr),
        .inc_i     (timer_inc),
        .expired_c (timer_expired)
    );

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q     <= ST_IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        pwrite_q <= cmd_write;
                        paddr_q  <= cmd_addr;
                        pwdata_q <= cmd_wdata;
                        psel_q   <= 1'b1;
                        state_q  <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // A completion on the limit edge beats the timeout.
                    if (PREADY) begin
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_q.rdata   <= pwrite_q ? '0 : APB_DATA_W'(PRDATA);
                        rsp_q.err     <= PSLVERR;
                        rsp_q.timeout <= 1'b0;
                        state_q       <= ST_IDLE;
                    end else if (timer_expired) begin
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_q.rdata   <= '0;
                        rsp_q.err     <= 1'b1;
                        rsp_q.timeout <= 1'b1;
                        state_q       <= ST_IDLE;
                    end
                end
                default: begin
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready   = (state_q == ST_IDLE);

    assign PSELx       = psel_q;
    assign PENABLE     = penable_q;
    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;

    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = DATA_WIDTH'(rsp_q.rdata);
    assign rsp_err     = rsp_q.err;
    assign rsp_timeout = rsp_q.timeout;

endmodule
